sad_search_sequencer: RTL and testbench
=======================================

// Module: sad_search_sequencer
// PURPOSE
//  Sequences the SAD window search over a frame held in data memory; feeds the Memory->SAD1->SAD2 datapath.
//  Walks candidate (x,y) positions in serpentine order and issues one window-address request per position.
//  Retires in-order SAD results and tracks the minimum SAD with its coordinates.
//  Sits beside the pipeline as the search controller: start/done toward decode, results back from SAD2.
// PARAMETERS
//  WIN      4   window edge in pixels (WIN x WIN block)
//  DIM_W    8   width of frame dimension and coordinate fields
//  ADDR_W   32  memory byte-address width
//  SAD_W    32  SAD value width
//  MAX_OUT  4   max issued-but-unretired requests (pipeline depth Memory..SAD2 plus slack)
// PORTS
//  Clk          in   1       clock, rising edge
//  Reset        in   1       asynchronous reset, active-low
//  start        in   1       pulse: begin search; sampled only in IDLE
//  cfg_w        in   DIM_W   frame width in pixels (sampled at start)
//  cfg_h        in   DIM_W   frame height in pixels (sampled at start)
//  base_addr    in   ADDR_W  frame base byte address, word per pixel (sampled at start)
//  issue_valid  out  1       request valid
//  issue_ready  in   1       pipeline accepts request (low = stall)
//  issue_addr   out  ADDR_W  base_addr + ((y*cfg_w + x) << 2)
//  issue_x      out  DIM_W   candidate x
//  issue_y      out  DIM_W   candidate y
//  result_valid in   1       SAD2 result valid, in issue order, no backpressure
//  result_sad   in   SAD_W   SAD of oldest outstanding request
//  busy         out  1       high in ISSUE or DRAIN
//  done         out  1       one-cycle pulse on search completion
//  err          out  1       sticky: bad config or unexpected result; cleared by next accepted start
//  min_sad      out  SAD_W   best SAD so far
//  min_x        out  DIM_W   x of best SAD
//  min_y        out  DIM_W   y of best SAD
// BEHAVIOUR
//  Reset: state IDLE; issue_valid=0, issue_addr/x/y=0, busy=0, done=0, err=0, min_sad=all-ones, min_x/y=0.
//  States: IDLE -start-> ISSUE; ISSUE -last position accepted-> DRAIN; DRAIN -outstanding==0-> DONE; DONE -> IDLE (1 cycle, done=1).
//  Bad config: cfg_w<WIN or cfg_h<WIN at start -> DONE next cycle, err=1, no issues, min_sad stays all-ones.
//  Positions: x in 0..cfg_w-WIN, y in 0..cfg_h-WIN. Even rows x ascends, odd rows x descends; y increments at row end.
//  On start: min_sad<=all-ones, min_x/y<=0, position (0,0), err<=0.
//  Issue: issue_valid=1 in ISSUE while outstanding<MAX_OUT; addr/x/y stable while valid && !ready.
//  Fire = issue_valid && issue_ready; position advances on the next edge. Request accepted = first cycle of fire.
//  Outstanding counter: +1 on fire, -1 on result_valid; both in same cycle -> unchanged.
//  Result tag: internal FIFO of depth MAX_OUT holds (x,y) per fire; popped on result_valid.
//  Min update: result_sad < min_sad (strict) -> load sad and popped (x,y). Ties keep earlier position.
//  result_valid with outstanding==0: ignored, err=1.
//  Address arithmetic: y*cfg_w at DIM_W*2 bits, zero-extended to ADDR_W, then <<2, then + base_addr, modulo 2^ADDR_W.
//  start while busy: ignored. Reset mid-search: immediate return to reset values, tag FIFO emptied.
//  Latency: first issue_valid one cycle after start; done one cycle after the last result is retired.
// CONFIGURATION
//  SAD_EARLY_EXIT_EN defined: a retired result_sad==0 in ISSUE stops issue (ISSUE->DRAIN); in-flight results still retired.
//    min_x/y hold the first zero-SAD position.
//  SAD_EARLY_EXIT_EN undefined: every position is always searched; a zero SAD does not change sequencing.
// STRUCTURE
//  Shared package sad_defs: state encodings (IDLE, ISSUE, DRAIN, DONE), WIN, DIM_W, SAD_W, SAD_MAX all-ones constant.
//  Sub-module sad_pos_gen: serpentine x/y counter with load/advance/last outputs.
//  The FSM, tag FIFO, outstanding counter and min tracker stay in this module.
// TESTING
//  1. 6x6 frame, base 0x100, ready=1, SAD=x+y+1 at fixed latency 3.
//     Issue order (0,0)(1,0)(2,0)(2,1)(1,1)(0,1)(0,2)(1,2)(2,2); min_sad=1 at (0,0); one done pulse.
//  2. Same frame, issue_ready low 5 cycles during the 2nd request -> addr 0x104 held stable; no loss or duplication.
//  3. Results with SAD 9,3,3,7: min_sad=3 at the 2nd position; tie ignored.
//  4. cfg_w=3 -> done 1 cycle after the start edge, err=1, issue_valid never rises.
//  5. Result latency 10 with MAX_OUT=4 -> issue_valid drops with 4 outstanding; issue resumes after the 1st result.
//  6. Reset low mid-ISSUE -> all outputs at reset values; a new start runs a full search correctly.
//     If SAD_EARLY_EXIT_EN: SAD 0 at the 3rd position -> no further issues after drain, min at (2,0).

Source files
------------

// File: rtl/sad_search_sequencer_pkg.sv
// Shared definitions for the SAD window search sequencer: sizes, state encoding, address helper.
package sad_defs;

    localparam int unsigned WIN     = 4;
    localparam int unsigned DIM_W   = 8;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned SAD_W   = 32;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned PROD_W  = 2 * DIM_W;

    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Word-per-pixel byte address of window origin (x,y); row product kept at 2*DIM_W bits.
    function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [DIM_W-1:0]  w,
                                                   input logic [DIM_W-1:0]  x,
                                                   input logic [DIM_W-1:0]  y);
        logic [PROD_W-1:0] row;
        row = PROD_W'(y) * PROD_W'(w);
        return base + ((ADDR_W'(row) + ADDR_W'(x)) << 2);
    endfunction

endpackage

// File: rtl/sad_search_sequencer_if.sv
// Search-control bus between the sequencer (master) and decode / SAD pipeline (slave).
interface sad_search_sequencer_if;
    import sad_defs::*;

    logic              start;
    logic [DIM_W-1:0]  cfg_w;
    logic [DIM_W-1:0]  cfg_h;
    logic [ADDR_W-1:0] base_addr;
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_addr;
    logic [DIM_W-1:0]  issue_x;
    logic [DIM_W-1:0]  issue_y;
    logic              result_valid;
    logic [SAD_W-1:0]  result_sad;
    logic              busy;
    logic              done;
    logic              err;
    logic [SAD_W-1:0]  min_sad;
    logic [DIM_W-1:0]  min_x;
    logic [DIM_W-1:0]  min_y;

    modport master (
        input  start, cfg_w, cfg_h, base_addr, issue_ready, result_valid, result_sad,
        output issue_valid, issue_addr, issue_x, issue_y, busy, done, err, min_sad, min_x, min_y
    );

    modport slave (
        output start, cfg_w, cfg_h, base_addr, issue_ready, result_valid, result_sad,
        input  issue_valid, issue_addr, issue_x, issue_y, busy, done, err, min_sad, min_x, min_y
    );

endinterface

// File: rtl/sad_pos_gen.sv
// Serpentine candidate-position counter: even rows walk x up, odd rows walk x down.
module sad_pos_gen
    import sad_defs::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [DIM_W-1:0] lim_x,
    input  logic [DIM_W-1:0] lim_y,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic [DIM_W-1:0] x_nxt_c,
    output logic [DIM_W-1:0] y_nxt_c,
    output logic             last_c
);

    logic rev;
    logic rev_nxt;
    logic row_end;

    // Advancing past the last position holds it, so the final address stays on the bus.
    always_comb begin
        row_end = rev ? (x == '0) : (x == lim_x);
        last_c  = row_end && (y == lim_y);
        x_nxt_c = x;
        y_nxt_c = y;
        rev_nxt = rev;
        if (load) begin
            x_nxt_c = '0;
            y_nxt_c = '0;
            rev_nxt = 1'b0;
        end else if (advance && !last_c) begin
            if (row_end) begin
                y_nxt_c = y + DIM_W'(1);
                rev_nxt = !rev;
            end else if (rev) begin
                x_nxt_c = x - DIM_W'(1);
            end else begin
                x_nxt_c = x + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            y   <= '0;
            rev <= 1'b0;
        end else begin
            x   <= x_nxt_c;
            y   <= y_nxt_c;
            rev <= rev_nxt;
        end
    end

endmodule

// File: rtl/sad_search_sequencer.sv
// SAD window search controller: issues window requests, retires results in order, tracks the minimum.
// Optional SAD_EARLY_EXIT_EN: a retired zero SAD during ISSUE stops further issue.
module sad_search_sequencer
    import sad_defs::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sad_search_sequencer_if.master bus
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [DIM_W-1:0]  cfg_w_q;
    logic [DIM_W-1:0]  cfg_h_q;
    logic [ADDR_W-1:0] base_q;
    logic [OUT_W-1:0]  out_cnt;
    logic [OUT_W-1:0]  out_nxt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DIM_W-1:0]  tag_x [MAX_OUT];
    logic [DIM_W-1:0]  tag_y [MAX_OUT];

    logic              issue_valid_q;
    logic [ADDR_W-1:0] issue_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [SAD_W-1:0]  min_sad_q;
    logic [DIM_W-1:0]  min_x_q;
    logic [DIM_W-1:0]  min_y_q;

    logic              start_ok;
    logic              cfg_bad;
    logic              fire;
    logic              pop;
    logic              stray;
    logic              better;
    logic              early_stop;
    logic [DIM_W-1:0]  pos_x;
    logic [DIM_W-1:0]  pos_y;
    logic [DIM_W-1:0]  x_nxt;
    logic [DIM_W-1:0]  y_nxt;
    logic              last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    sad_pos_gen u_pos_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_ok),
        .advance (fire),
        .lim_x   (cfg_w_q - DIM_W'(WIN)),
        .lim_y   (cfg_h_q - DIM_W'(WIN)),
        .x       (pos_x),
        .y       (pos_y),
        .x_nxt_c (x_nxt),
        .y_nxt_c (y_nxt),
        .last_c  (last)
    );

    // Handshake decode, outstanding bookkeeping and next state.
    always_comb begin
        start_ok   = (state == IDLE) && bus.start;
        cfg_bad    = (bus.cfg_w < DIM_W'(WIN)) || (bus.cfg_h < DIM_W'(WIN));
        fire       = issue_valid_q && bus.issue_ready;
        pop        = bus.result_valid && (out_cnt != '0);
        stray      = bus.result_valid && (out_cnt == '0);
        better     = pop && (bus.result_sad < min_sad_q);
        out_nxt    = out_cnt + OUT_W'(fire) - OUT_W'(pop);
`ifdef SAD_EARLY_EXIT_EN
        early_stop = pop && (bus.result_sad == '0) && (state == ISSUE);
`else
        early_stop = 1'b0;
`endif
        state_nxt  = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = cfg_bad ? DONE : ISSUE;
            ISSUE:   if ((fire && last) || early_stop) state_nxt = DRAIN;
            DRAIN:   if (out_nxt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tag FIFO payload: position of each accepted request, consumed in result order.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_x[wr_ptr] <= pos_x;
            tag_y[wr_ptr] <= pos_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cfg_w_q       <= '0;
            cfg_h_q       <= '0;
            base_q        <= '0;
            out_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            issue_valid_q <= 1'b0;
            issue_addr_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            min_sad_q     <= SAD_MAX;
            min_x_q       <= '0;
            min_y_q       <= '0;
        end else begin
            state         <= state_nxt;
            out_cnt       <= out_nxt;
            busy_q        <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            done_q        <= (state_nxt == DONE);
            issue_valid_q <= (state_nxt == ISSUE) && (out_nxt < OUT_W'(MAX_OUT));
            if (fire) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (start_ok) begin
                cfg_w_q      <= bus.cfg_w;
                cfg_h_q      <= bus.cfg_h;
                base_q       <= bus.base_addr;
                issue_addr_q <= bus.base_addr;
                err_q        <= cfg_bad;
                min_sad_q    <= SAD_MAX;
                min_x_q      <= '0;
                min_y_q      <= '0;
            end else begin
                if (fire)  issue_addr_q <= win_addr(base_q, cfg_w_q, x_nxt, y_nxt);
                if (stray) err_q <= 1'b1;
                if (better) begin
                    min_sad_q <= bus.result_sad;
                    min_x_q   <= tag_x[rd_ptr];
                    min_y_q   <= tag_y[rd_ptr];
                end
            end
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_addr  = issue_addr_q;
    assign bus.issue_x     = pos_x;
    assign bus.issue_y     = pos_y;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.min_sad     = min_sad_q;
    assign bus.min_x       = min_x_q;
    assign bus.min_y       = min_y_q;

endmodule

// File: tb/tb_sad_search_sequencer.sv
// Directed bench for sad_search_sequencer: models the SAD pipeline as a fixed-latency in-order result queue.
module tb_sad_search_sequencer;
    import sad_defs::*;

    logic clk;
    logic rst_n;

    sad_search_sequencer_if bus ();

    sad_search_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    int          log_x[$];
    int          log_y[$];
    logic [31:0] log_a[$];
    int          q_due[$];
    int          q_sad[$];
    int          sad_mode;
    int          done_cnt, done_cyc, first_res_cyc, last_res_cyc, fire5_cyc;
    int          max_out, valid_at_full, stall_bad;
    logic [31:0] hold_addr;
    int          exp_x[9] = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
    int          exp_y[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int          seq3[9]  = '{9, 3, 3, 7, 20, 20, 20, 20, 20};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sad_of(input int k, input int x, input int y);
        case (sad_mode)
            1:       return seq3[k];
            2:       return (k == 2) ? 0 : 5;
            default: return x + y + 1;
        endcase
    endfunction

    // Start one search and act as the pipeline cycle by cycle until done (plus a short tail).
    task automatic run_search(input int w, input int h, input logic [31:0] base, input int lat,
                              input int stall_at, input int stall_len, input int budget,
                              input bit expect_done);
        int stalled, tail, nout;
        bit seen;
        log_x.delete(); log_y.delete(); log_a.delete(); q_due.delete(); q_sad.delete();
        done_cnt = 0; done_cyc = -1; first_res_cyc = -1; last_res_cyc = -1; fire5_cyc = -1;
        max_out = 0; valid_at_full = 0; stall_bad = 0; hold_addr = '0;
        stalled = 0; tail = 0; nout = 0; seen = 1'b0;
        @(negedge clk);
        bus.cfg_w = DIM_W'(w); bus.cfg_h = DIM_W'(h); bus.base_addr = base;
        bus.start = 1'b1; bus.issue_ready = 1'b1; bus.result_valid = 1'b0; bus.result_sad = '0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < budget && tail < 3; c++) begin
            if (bus.done) begin
                done_cnt++;
                if (!seen) done_cyc = c;
                seen = 1'b1;
            end
            if (seen) tail++;
            if (nout > max_out) max_out = nout;
            if (bus.issue_valid && nout >= int'(MAX_OUT)) valid_at_full++;
            bus.issue_ready = 1'b1;
            if (bus.issue_valid && log_x.size() == stall_at && stalled < stall_len) begin
                if (stalled == 0) hold_addr = bus.issue_addr;
                if (bus.issue_addr !== hold_addr) stall_bad++;
                bus.issue_ready = 1'b0;
                stalled++;
            end
            if (bus.issue_valid && bus.issue_ready) begin
                log_x.push_back(int'(bus.issue_x));
                log_y.push_back(int'(bus.issue_y));
                log_a.push_back(bus.issue_addr);
                if (log_x.size() == 5) fire5_cyc = c;
                q_due.push_back(c + lat);
                q_sad.push_back(sad_of(log_x.size() - 1, int'(bus.issue_x), int'(bus.issue_y)));
                nout++;
            end
            bus.result_valid = 1'b0;
            if (q_due.size() > 0 && q_due[0] == c) begin
                bus.result_valid = 1'b1;
                bus.result_sad   = SAD_W'(q_sad.pop_front());
                void'(q_due.pop_front());
                nout--;
                if (first_res_cyc < 0) first_res_cyc = c;
                last_res_cyc = c;
            end
            @(negedge clk);
        end
        bus.issue_ready  = 1'b1;
        bus.result_valid = 1'b0;
        if (expect_done) check_eq("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_order(input string tag, input logic [31:0] base, input int w, input int n);
        check_eq({tag, "_count"}, 32'(log_x.size()), 32'(n));
        for (int i = 0; i < n && i < log_x.size(); i++) begin
            check_eq($sformatf("%s_x%0d", tag, i), 32'(log_x[i]), 32'(exp_x[i]));
            check_eq($sformatf("%s_y%0d", tag, i), 32'(log_y[i]), 32'(exp_y[i]));
            check_eq($sformatf("%s_a%0d", tag, i), log_a[i], base + 32'((exp_y[i] * w + exp_x[i]) * 4));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.issue_valid), 32'd0);
        check_eq({tag, "_addr"},  bus.issue_addr, 32'd0);
        check_eq({tag, "_xy"},    {16'd0, bus.issue_x, bus.issue_y}, 32'd0);
        check_eq({tag, "_flags"}, {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
        check_eq({tag, "_minsad"}, bus.min_sad, 32'hFFFF_FFFF);
        check_eq({tag, "_minxy"}, {16'd0, bus.min_x, bus.min_y}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.cfg_w = '0; bus.cfg_h = '0; bus.base_addr = '0;
        bus.issue_ready = 1'b1; bus.result_valid = 1'b0; bus.result_sad = '0;
        sad_mode = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // 1: full 6x6 search, SAD = x+y+1, latency 3
        run_search(6, 6, 32'h100, 3, -1, 0, 200, 1'b1);
        check_order("t1", 32'h100, 6, 9);
        check_eq("t1_minsad", bus.min_sad, 32'd1);
        check_eq("t1_minxy", {16'd0, bus.min_x, bus.min_y}, 32'd0);
        check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t1_done_cyc", 32'(done_cyc), 32'd12);
        check_eq("t1_err", 32'(bus.err), 32'd0);
        check_eq("t1_busy", 32'(bus.busy), 32'd0);

        // Result with nothing outstanding flags err.
        @(negedge clk); bus.result_valid = 1'b1; bus.result_sad = 32'd0;
        @(negedge clk); bus.result_valid = 1'b0;
        check_eq("stray_err", 32'(bus.err), 32'd1);
        check_eq("stray_minsad", bus.min_sad, 32'd1);

        // 2: stall the 2nd request for 5 cycles
        run_search(6, 6, 32'h100, 3, 1, 5, 200, 1'b1);
        check_order("t2", 32'h100, 6, 9);
        check_eq("t2_hold_addr", hold_addr, 32'h104);
        check_eq("t2_stall_bad", 32'(stall_bad), 32'd0);
        check_eq("t2_err_cleared", 32'(bus.err), 32'd0);
        check_eq("t2_done_cnt", 32'(done_cnt), 32'd1);

        // 3: SAD 9,3,3,7,... -> first 3 wins
        sad_mode = 1;
        run_search(6, 6, 32'h100, 3, -1, 0, 200, 1'b1);
        check_eq("t3_minsad", bus.min_sad, 32'd3);
        check_eq("t3_minx", 32'(bus.min_x), 32'd1);
        check_eq("t3_miny", 32'(bus.min_y), 32'd0);

        // 4: bad config
        sad_mode = 0;
        run_search(3, 6, 32'h100, 3, -1, 0, 20, 1'b1);
        check_eq("t4_done_cyc", 32'(done_cyc), 32'd0);
        check_eq("t4_err", 32'(bus.err), 32'd1);
        check_eq("t4_issues", 32'(log_x.size()), 32'd0);
        check_eq("t4_minsad", bus.min_sad, 32'hFFFF_FFFF);
        check_eq("t4_done_cnt", 32'(done_cnt), 32'd1);

        // 5: latency 10 fills the outstanding window
        run_search(6, 6, 32'h200, 10, -1, 0, 300, 1'b1);
        check_order("t5", 32'h200, 6, 9);
        check_eq("t5_max_out", 32'(max_out), 32'd4);
        check_eq("t5_valid_full", 32'(valid_at_full), 32'd0);
        check_eq("t5_first_res", 32'(first_res_cyc), 32'd10);
        check_eq("t5_fire5", 32'(fire5_cyc), 32'd11);
        check_eq("t5_done_cyc", 32'(done_cyc), 32'(last_res_cyc + 1));
        check_eq("t5_minsad", bus.min_sad, 32'd1);

        // 6: reset mid-ISSUE, then a clean search
        run_search(6, 6, 32'h100, 3, -1, 0, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_search(6, 6, 32'h300, 3, -1, 0, 200, 1'b1);
        check_order("t6", 32'h300, 6, 9);
        check_eq("t6_minsad", bus.min_sad, 32'd1);
        check_eq("t6_done_cnt", 32'(done_cnt), 32'd1);

        // 7: zero SAD at the 3rd position
        sad_mode = 2;
        run_search(6, 6, 32'h100, 3, -1, 0, 200, 1'b1);
`ifdef SAD_EARLY_EXIT_EN
        check_eq("t7_issues", 32'(log_x.size()), 32'd6);
        check_eq("t7_done_cyc", 32'(done_cyc), 32'd9);
`else
        check_eq("t7_issues", 32'(log_x.size()), 32'd9);
        check_eq("t7_done_cyc", 32'(done_cyc), 32'd12);
`endif
        check_eq("t7_minsad", bus.min_sad, 32'd0);
        check_eq("t7_minx", 32'(bus.min_x), 32'd2);
        check_eq("t7_miny", 32'(bus.min_y), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
